// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction-fetch and data
// requesters, with per-side stalls and result holding until the pipeline advances.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_stall,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                m_req,
  output logic [DATA_W/8-1:0] m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                timeout_err,
  output logic [1:0]          dbg_state
);

  // Handshake: a request is held on m_req/m_* unchanged until the memory
  // answers with m_ready=1 in the same cycle; that cycle completes it.

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } state_t;

  state_t           state;
  logic             i_hold;
  logic             d_hold;
  logic [CNT_W-1:0] wait_cnt;

  assign i_stall   = i_req & ~i_hold;
  assign d_stall   = d_req & ~d_hold;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      m_req       <= 1'b0;
      m_we        <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_hold      <= 1'b0;
      d_hold      <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Completion below overrides this clear for the side that completes.
      if (advance) begin
        i_hold <= 1'b0;
        d_hold <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (d_req && !d_hold) begin
            m_req    <= 1'b1;
            m_we     <= d_we;
            m_addr   <= d_addr;
            m_wdata  <= d_wdata;
            wait_cnt <= '0;
            state    <= D_BUSY;
          end else if (i_req && !i_hold) begin
            m_req    <= 1'b1;
            m_we     <= '0;
            m_addr   <= i_addr;
            wait_cnt <= '0;
            state    <= I_BUSY;
          end
        end
        D_BUSY, I_BUSY: begin
          if (m_ready) begin
            m_req <= 1'b0;
            state <= IDLE;
            // A dropped request means the access was flushed; discard it.
            if (state == D_BUSY && d_req) begin
              d_hold <= 1'b1;
              if (m_we == '0) d_rdata <= m_rdata;
            end
            if (state == I_BUSY && i_req) begin
              i_hold  <= 1'b1;
              i_rdata <= m_rdata;
            end
          end else if (TIMEOUT != 0 && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_ONE;
            if (wait_cnt + CNT_ONE == CNT_MAX) timeout_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction table plus hand-written
// sequences for latency, priority, stores, flush, timeout and async reset.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          advance = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_stall;
  logic          d_req = 1'b0;
  logic [3:0]    d_we = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic          m_req;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .advance(advance),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic release_side();
    advance = 1'b1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    @(negedge clk);
    advance = 1'b0;
  endtask

  typedef struct {
    logic        is_d;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    int          waits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 4'b0000, 32'h0040_0000, 32'h0,         32'h2402_0001, 0, 32'h2402_0001};
    vecs[1] = '{1'b1, 4'b0000, 32'h1001_0000, 32'h0,         32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 4'b1111, 32'h1001_0004, 32'h1234_5678, 32'h5555_5555, 1, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 4'b0000, 32'h0040_0004, 32'h0,         32'h8C43_0000, 3, 32'h8C43_0000};
    vecs[4] = '{1'b1, 4'b1000, 32'h1001_0008, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 4'b0000, 32'h1001_000C, 32'h0,         32'h0BAD_F00D, 1, 32'h0BAD_F00D};

    // reset state
    repeat (2) @(negedge clk);
    check("rst m_req", {31'b0, m_req}, 32'h0);
    check("rst m_we", {28'b0, m_we}, 32'h0);
    check("rst m_addr", m_addr, 32'h0);
    check("rst m_wdata", m_wdata, 32'h0);
    check("rst i_rdata", i_rdata, 32'h0);
    check("rst d_rdata", d_rdata, 32'h0);
    check("rst timeout_err", {31'b0, timeout_err}, 32'h0);
    check("rst state", {30'b0, dbg_state}, 32'h0);
    check("rst stalls", {30'b0, i_stall, d_stall}, 32'h0);
    rst = 1'b0;

    // table-driven single transactions
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (vecs[n].is_d) begin
        d_req = 1'b1; d_we = vecs[n].we; d_addr = vecs[n].addr; d_wdata = vecs[n].wdata;
      end else begin
        i_req = 1'b1; i_addr = vecs[n].addr;
      end
      #1 check($sformatf("vec%0d stall on", n), {31'b0, vecs[n].is_d ? d_stall : i_stall}, 32'h1);
      @(negedge clk);
      check($sformatf("vec%0d m_req", n), {31'b0, m_req}, 32'h1);
      check($sformatf("vec%0d m_addr", n), m_addr, vecs[n].addr);
      check($sformatf("vec%0d m_we", n), {28'b0, m_we}, {28'b0, vecs[n].is_d ? vecs[n].we : 4'b0000});
      if (vecs[n].is_d) check($sformatf("vec%0d m_wdata", n), m_wdata, vecs[n].wdata);
      for (int w = 0; w < vecs[n].waits; w++) begin
        @(negedge clk);
        check($sformatf("vec%0d wait m_req", n), {31'b0, m_req}, 32'h1);
      end
      m_ready = 1'b1; m_rdata = vecs[n].mem_data;
      @(negedge clk);
      m_ready = 1'b0; m_rdata = 32'h0;
      #1 check($sformatf("vec%0d stall off", n), {31'b0, vecs[n].is_d ? d_stall : i_stall}, 32'h0);
      check($sformatf("vec%0d rdata", n), vecs[n].is_d ? d_rdata : i_rdata, vecs[n].exp_rdata);
      check($sformatf("vec%0d m_req off", n), {31'b0, m_req}, 32'h0);
      release_side();
    end

    // single fetch: 2 stall cycles, then next fetch after advance
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    #1 check("fetch stall c0", {31'b0, i_stall}, 32'h1);
    @(negedge clk);
    check("fetch stall c1", {31'b0, i_stall}, 32'h1);
    check("fetch m_addr", m_addr, 32'hBFC0_0000);
    m_ready = 1'b1; m_rdata = 32'h3C08_BFAF;
    @(negedge clk);
    m_ready = 1'b0;
    #1 check("fetch stall c2", {31'b0, i_stall}, 32'h0);
    check("fetch i_rdata", i_rdata, 32'h3C08_BFAF);
    advance = 1'b1; i_addr = 32'hBFC0_0004;
    @(negedge clk);
    advance = 1'b0;
    #1 check("fetch2 stall", {31'b0, i_stall}, 32'h1);
    check("fetch2 not yet issued", {31'b0, m_req}, 32'h0);
    @(negedge clk);
    check("fetch2 m_req", {31'b0, m_req}, 32'h1);
    check("fetch2 m_addr", m_addr, 32'hBFC0_0004);
    m_ready = 1'b1; m_rdata = 32'h27BD_FFE0;
    @(negedge clk);
    m_ready = 1'b0;
    check("fetch2 i_rdata", i_rdata, 32'h27BD_FFE0);
    release_side();

    // simultaneous requests: D first, then I, no reissue while held
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0040_0100;
    d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h8000_0010;
    #1 check("sim both stall", {30'b0, i_stall, d_stall}, 32'h3);
    @(negedge clk);
    check("sim D first addr", m_addr, 32'h8000_0010);
    check("sim D_BUSY", {30'b0, dbg_state}, 32'h1);
    m_ready = 1'b1; m_rdata = 32'h1111_2222;
    @(negedge clk);
    m_ready = 1'b0;
    #1 check("sim stalls after D", {30'b0, i_stall, d_stall}, 32'h2);
    check("sim d_rdata", d_rdata, 32'h1111_2222);
    @(negedge clk);
    check("sim I addr", m_addr, 32'h0040_0100);
    check("sim I_BUSY", {30'b0, dbg_state}, 32'h2);
    m_ready = 1'b1; m_rdata = 32'h03E0_0008;
    @(negedge clk);
    m_ready = 1'b0;
    #1 check("sim stalls done", {30'b0, i_stall, d_stall}, 32'h0);
    check("sim i_rdata", i_rdata, 32'h03E0_0008);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("sim no reissue", {31'b0, m_req}, 32'h0);
    end
    release_side();

    // store held stable across 3 wait cycles; d_rdata untouched
    @(negedge clk);
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d_addr = 32'h0000_0200; d_wdata = 32'h0;
      m_rdata = 32'h9999_9999;
      check("store m_req", {31'b0, m_req}, 32'h1);
      check("store m_we", {28'b0, m_we}, 32'h3);
      check("store m_addr", m_addr, 32'h0000_0100);
      check("store m_wdata", m_wdata, 32'hDEAD_BEEF);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    #1 check("store d_stall", {31'b0, d_stall}, 32'h0);
    check("store d_rdata kept", d_rdata, 32'h1111_2222);
    check("store no timeout", {31'b0, timeout_err}, 32'h0);
    release_side();

    // flush: fetch dropped while busy is discarded
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0040_0200;
    @(negedge clk);
    check("flush I_BUSY", {30'b0, dbg_state}, 32'h2);
    i_req = 1'b0; m_ready = 1'b1; m_rdata = 32'h7777_7777;
    @(negedge clk);
    m_ready = 1'b0;
    check("flush i_rdata kept", i_rdata, 32'h03E0_0008);
    check("flush idle", {30'b0, dbg_state}, 32'h0);
    @(negedge clk);
    check("flush no issue", {31'b0, m_req}, 32'h0);
    i_req = 1'b1;
    #1 check("flush hold clear", {31'b0, i_stall}, 32'h1);
    @(negedge clk);
    check("flush reissue", {31'b0, m_req}, 32'h1);
    check("flush reissue addr", m_addr, 32'h0040_0200);
    m_ready = 1'b1; m_rdata = 32'h0000_0001;
    @(negedge clk);
    m_ready = 1'b0;
    check("flush new rdata", i_rdata, 32'h0000_0001);
    release_side();

    // timeout with TIMEOUT=4: m_ready low for 6 cycles
    @(negedge clk);
    d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h0000_0300;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("timeout w%0d", k), {31'b0, timeout_err}, {31'b0, k >= 5});
    end
    m_ready = 1'b1; m_rdata = 32'h0000_0044;
    @(negedge clk);
    m_ready = 1'b0;
    check("timeout d_rdata", d_rdata, 32'h0000_0044);
    check("timeout sticky", {31'b0, timeout_err}, 32'h1);
    release_side();
    @(negedge clk);
    check("timeout sticky later", {31'b0, timeout_err}, 32'h1);

    // asynchronous reset in D_BUSY
    d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h0000_0400;
    @(negedge clk);
    check("mid D_BUSY", {30'b0, dbg_state}, 32'h1);
    d_req = 1'b0;
    #2 rst = 1'b1;
    #1 check("async m_req", {31'b0, m_req}, 32'h0);
    check("async stalls", {30'b0, i_stall, d_stall}, 32'h0);
    check("async state", {30'b0, dbg_state}, 32'h0);
    check("async timeout_err", {31'b0, timeout_err}, 32'h0);
    check("async m_addr", m_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst idle", {30'b0, dbg_state}, 32'h0);
    check("post rst m_req", {31'b0, m_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction-fetch side and data-access side.
- Sits between the pipelined MIPS core (PC/Instr_en and Mem_addr/Mem_en/Mem_write_en) and the unified memory.
- Serialises the two requesters and returns per-side stall signals to the core.
- Holds each completed result until the pipeline actually advances.

Parameters:
- ADDR_W, 32: address width for both sides and the memory port.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- TIMEOUT, 255: number of cycles m_ready may stay low before the error flag sets. 0 disables the check.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- advance  in  1  the pipeline moves at the end of this cycle (no global stall).
- i_req  in  1  fetch request (from Instr_en).
- i_addr  in  ADDR_W  fetch address (PC).
- i_rdata  out  DATA_W  fetched instruction.
- i_stall  out  1  fetch not yet satisfied.
- d_req  in  1  data request (Mem_en).
- d_we  in  DATA_W/8  byte write enables; all-zero means load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_stall  out  1  data access not yet satisfied.
- m_req  out  1  memory request.
- m_we  out  DATA_W/8  memory byte enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid when m_ready=1.
- m_ready  in  1  memory completes the current request this cycle.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst=1) sets: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0, i_hold=0, d_hold=0, wait counter=0, timeout_err=0. A reset mid-transaction abandons it; the memory model is reset by the same rst.
- Stall outputs are combinational: i_stall = i_req & ~i_hold; d_stall = d_req & ~d_hold. Neither depends on advance, so there is no combinational loop.
- FSM states: IDLE, D_BUSY, I_BUSY.
- IDLE:
  - If d_req & ~d_hold, latch d_addr/d_we/d_wdata into m_* registers, set m_req=1, go to D_BUSY.
  - Else if i_req & ~i_hold, latch i_addr with m_we=0, set m_req=1, go to I_BUSY.
  - D has priority because it belongs to the older instruction.
- D_BUSY / I_BUSY:
  - m_req and m_* stay stable until m_ready=1.
  - On m_ready: m_req=0, go to IDLE.
  - If the requester is still asserted, set its hold flag. For a load or a fetch, also capture m_rdata into d_rdata/i_rdata; a store leaves d_rdata unchanged.
  - If the requester dropped its req (flush), discard the result and do not set hold.
- Minimum latency: request visible in cycle 0, m_req high in cycle 1. With m_ready in cycle 1, the stall drops in cycle 2, giving 2 cycles of stall.
- A new request cannot issue in the cycle m_ready is seen. The next issue is from IDLE one cycle later, so back-to-back accesses cost 2 cycles each plus memory wait.
- Hold flags:
  - Set on completion as above.
  - Cleared at any edge where advance=1; clear takes priority over set only if both occur in the same cycle for different requests (not possible by construction).
  - While a hold flag is set, that side is never reissued, even if its req stays high.
- Both sides are satisfied independently. A held fetch keeps i_rdata stable while a D access proceeds.
- i_rdata/d_rdata change only on capture.
- Wait counter:
  - Counts cycles in a BUSY state with m_ready=0; clears on every issue.
  - When the count reaches TIMEOUT (and TIMEOUT≠0), set timeout_err=1; it is cleared only by rst.
  - The transaction keeps waiting.
  - The counter saturates at TIMEOUT.
- Address and data from requesters are sampled only at issue; changes while BUSY are ignored.

Test Plan:
- Single fetch:
  - Stimulus: after reset, i_req=1, i_addr=0xBFC00000, memory returns 0x3C08BFAF with m_ready one cycle after m_req.
  - Required: i_stall high for 2 cycles, then low with i_rdata=0x3C08BFAF.
  - Then with advance=1 and i_addr=0xBFC00004, a new fetch issues.
- Simultaneous requests:
  - Stimulus: i_req=d_req=1, d_we=0, d_addr=0x80000010; advance=0 until both stalls are low.
  - Required: the D access issues first and d_rdata is captured. Then I issues. Both stalls end low, and neither reissues until advance=1.
- Store:
  - Stimulus: d_we=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF.
  - Required: m_we=0011, m_addr=0x100, m_wdata=0xDEADBEEF held stable across 3 wait cycles. d_rdata is unchanged.
- Flush:
  - Stimulus: i_req drops while I_BUSY.
  - Required: the result is discarded and i_hold stays 0. The next i_req issues a fresh access.
- Timeout with TIMEOUT=4:
  - Stimulus: m_ready held low for 6 cycles.
  - Required: timeout_err rises after 4 wait cycles and stays high after completion until rst.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously in D_BUSY.
  - Required: m_req=0 and all stalls low immediately (if req=0), with state IDLE on release.
